// File: rtl/bram_uart_streamer_if.sv
// Bus between the BRAM readback streamer, its BRAM read port and the UART transmitter.
// tx_valid/tx_ready: a byte moves on a rising edge with tx_valid & tx_ready; tx_data is held while tx_valid waits.
interface bram_uart_streamer_if #(
   parameter int ADDR_W = 10
);
   logic              start;
   logic [ADDR_W-1:0] addr_b;
   logic [7:0]        data_ram;
   logic [7:0]        tx_data;
   logic              tx_valid;
   logic              tx_ready;
   logic              busy;
   logic              done;
   logic [ADDR_W:0]   byte_count;
   logic [15:0]       checksum;
   logic [2:0]        dbg_state;

   modport master (
      input  start, data_ram, tx_ready,
      output addr_b, tx_data, tx_valid, busy, done, byte_count, checksum, dbg_state
   );

   modport slave (
      output start, data_ram, tx_ready,
      input  addr_b, tx_data, tx_valid, busy, done, byte_count, checksum, dbg_state
   );
endinterface

// File: rtl/bram_uart_streamer.sv
// Sweeps the image BRAM from address 0 to DEPTH-1, streams each byte to the UART
// transmitter, then appends the 16-bit additive checksum of the image, high byte first.
module bram_uart_streamer #(
   parameter int DEPTH    = 1024,
   parameter int ADDR_W   = 10,
   parameter int READ_LAT = 1
) (
   input  logic                clk,
   input  logic                rst,
   bram_uart_streamer_if.master bus
);
   typedef enum logic [2:0] {
      S_IDLE, S_READ, S_SEND, S_CSH, S_CSH_W, S_CSL, S_CSL_W, S_DONE
   } state_t;

   localparam int              WAIT_W   = (READ_LAT < 1) ? 1 : $clog2(READ_LAT + 1);
   localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W + 1)'(DEPTH - 1);
   localparam logic [WAIT_W-1:0] WAIT_END = WAIT_W'(READ_LAT);

   state_t              r_state;
   logic [WAIT_W-1:0]   r_wait;
   logic [ADDR_W-1:0]   r_addr;
   logic [7:0]          r_tx_data;
   logic                r_tx_valid;
   logic                r_busy;
   logic                r_done;
   logic [ADDR_W:0]     r_byte_count;
   logic [15:0]         r_checksum;
   logic                w_xfer;

   assign w_xfer = r_tx_valid & bus.tx_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_wait       <= '0;
         r_addr       <= '0;
         r_tx_data    <= '0;
         r_tx_valid   <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_byte_count <= '0;
         r_checksum   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_checksum   <= '0;
                  r_byte_count <= '0;
                  r_addr       <= '0;
                  r_wait       <= '0;
                  r_busy       <= 1'b1;
                  r_state      <= S_READ;
               end
            end
            // Data is sampled on the edge after the BRAM pipeline has settled.
            S_READ: begin
               if (r_wait == WAIT_END) begin
                  r_wait     <= '0;
                  r_tx_data  <= bus.data_ram;
                  r_tx_valid <= 1'b1;
                  r_state    <= S_SEND;
               end else begin
                  r_wait <= r_wait + 1'b1;
               end
            end
            S_SEND: begin
               if (w_xfer) begin
                  r_checksum   <= r_checksum + {8'h00, r_tx_data};
                  r_byte_count <= r_byte_count + 1'b1;
                  r_tx_valid   <= 1'b0;
                  if (r_byte_count == LAST_CNT) begin
                     r_state <= S_CSH;
                  end else begin
                     r_addr  <= r_addr + 1'b1;
                     r_state <= S_READ;
                  end
               end
            end
            S_CSH: begin
               r_tx_data  <= r_checksum[15:8];
               r_tx_valid <= 1'b1;
               r_state    <= S_CSH_W;
            end
            S_CSH_W: begin
               if (w_xfer) begin
                  r_tx_valid <= 1'b0;
                  r_state    <= S_CSL;
               end
            end
            S_CSL: begin
               r_tx_data  <= r_checksum[7:0];
               r_tx_valid <= 1'b1;
               r_state    <= S_CSL_W;
            end
            S_CSL_W: begin
               if (w_xfer) begin
                  r_tx_valid <= 1'b0;
                  r_done     <= 1'b1;
                  r_state    <= S_DONE;
               end
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_addr  <= '0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.addr_b     = r_addr;
   assign bus.tx_data    = r_tx_data;
   assign bus.tx_valid   = r_tx_valid;
   assign bus.busy       = r_busy;
   assign bus.done       = r_done;
   assign bus.byte_count = r_byte_count;
   assign bus.checksum   = r_checksum;
   assign bus.dbg_state  = r_state;
endmodule

// File: tb/tb_bram_uart_streamer.sv
// Directed bench: three streamer configurations sharing one clock/reset, BRAM models
// with the configured read latency, and a shared byte scoreboard.
module tb_bram_uart_streamer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;
   int   done_cnt = 0;

   logic [7:0] got_q[$];
   logic [7:0] exp_q[$];

   logic [7:0] mem_a [1024];
   logic [7:0] mem_b [4];
   logic [7:0] mem_c [2];
   logic [7:0] pa;
   logic [7:0] pb;
   logic [7:0] pc [3];

   always #5 clk = ~clk;

   bram_uart_streamer_if #(.ADDR_W(10)) a_if ();
   bram_uart_streamer_if #(.ADDR_W(2))  b_if ();
   bram_uart_streamer_if #(.ADDR_W(1))  c_if ();

   bram_uart_streamer #(.DEPTH(1024), .ADDR_W(10), .READ_LAT(1)) u_a (.clk(clk), .rst(rst), .bus(a_if));
   bram_uart_streamer #(.DEPTH(4),    .ADDR_W(2),  .READ_LAT(1)) u_b (.clk(clk), .rst(rst), .bus(b_if));
   bram_uart_streamer #(.DEPTH(2),    .ADDR_W(1),  .READ_LAT(3)) u_c (.clk(clk), .rst(rst), .bus(c_if));

   // BRAM models: READ_LAT register stages after the address
   always @(posedge clk) begin
      pa    <= mem_a[a_if.addr_b];
      pb    <= mem_b[b_if.addr_b];
      pc[0] <= mem_c[c_if.addr_b];
      pc[1] <= pc[0];
      pc[2] <= pc[1];
   end
   assign a_if.data_ram = pa;
   assign b_if.data_ram = pb;
   assign c_if.data_ram = pc[2];

   always @(negedge clk) begin
      if (!rst) begin
         if (a_if.tx_valid && a_if.tx_ready) got_q.push_back(a_if.tx_data);
         if (b_if.tx_valid && b_if.tx_ready) got_q.push_back(b_if.tx_data);
         if (c_if.tx_valid && c_if.tx_ready) got_q.push_back(c_if.tx_data);
         if (a_if.done) done_cnt++;
         if (b_if.done) done_cnt++;
         if (c_if.done) done_cnt++;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cmp_q(input string tag);
      chk({tag, "_len"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         chk($sformatf("%s[%0d]", tag, i), got_q[i], exp_q[i]);
   endtask

   task automatic build_exp_a();
      logic [15:0] sum;
      sum = '0;
      exp_q.delete();
      for (int i = 0; i < 1024; i++) begin
         exp_q.push_back(mem_a[i]);
         sum = sum + {8'h00, mem_a[i]};
      end
      exp_q.push_back(sum[15:8]);
      exp_q.push_back(sum[7:0]);
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int n;
      n = 0;
      while ((a_if.busy || b_if.busy || c_if.busy) && n < budget) begin
         tick();
         n++;
      end
      chk({tag, "_timeout"}, 32'(n < budget), 1);
   endtask

   task automatic wait_got(input string tag, input int k, input int budget);
      int n;
      n = 0;
      while (got_q.size() < k && n < budget) begin
         tick();
         n++;
      end
      chk({tag, "_wait"}, 32'(n < budget), 1);
   endtask

   task automatic new_frame();
      got_q.delete();
      done_cnt = 0;
   endtask

   task automatic start_a();
      a_if.start = 1'b1;
      tick();
      a_if.start = 1'b0;
   endtask

   initial begin
      int n;
      a_if.start = 1'b0; b_if.start = 1'b0; c_if.start = 1'b0;
      a_if.tx_ready = 1'b1; b_if.tx_ready = 1'b1; c_if.tx_ready = 1'b1;
      for (int i = 0; i < 1024; i++) mem_a[i] = 8'(i);
      mem_b[0] = 8'h10; mem_b[1] = 8'h20; mem_b[2] = 8'h30; mem_b[3] = 8'h40;
      mem_c[0] = 8'hAB; mem_c[1] = 8'hCD;

      // reset state
      #1;
      chk("rst_busy", a_if.busy, 0);
      chk("rst_valid", a_if.tx_valid, 0);
      chk("rst_addr", a_if.addr_b, 0);
      chk("rst_cksum", a_if.checksum, 0);
      chk("rst_count", a_if.byte_count, 0);
      chk("rst_done", a_if.done, 0);
      chk("rst_state", a_if.dbg_state, 0);
      repeat (3) tick();
      rst = 1'b0;
      tick();

      // ramp image, first-valid latency 2
      build_exp_a();
      new_frame();
      start_a();
      chk("ramp_busy", a_if.busy, 1);
      chk("ramp_addr0", a_if.addr_b, 0);
      n = 0;
      while (!a_if.tx_valid && n < 20) begin
         tick();
         n++;
      end
      chk("ramp_latency", n, 2);
      wait_idle("ramp", 5000);
      cmp_q("ramp");
      chk("ramp_cksum", a_if.checksum, 32'hFE00);
      chk("ramp_count", a_if.byte_count, 1024);
      chk("ramp_trl_hi", got_q[1024], 8'hFE);
      chk("ramp_trl_lo", got_q[1025], 8'h00);
      chk("ramp_done", done_cnt, 1);
      chk("ramp_addr_end", a_if.addr_b, 0);

      // all-0xFF image, checksum wraps
      for (int i = 0; i < 1024; i++) mem_a[i] = 8'hFF;
      build_exp_a();
      new_frame();
      start_a();
      wait_idle("ff", 5000);
      cmp_q("ff");
      chk("ff_cksum", a_if.checksum, 32'hFC00);
      chk("ff_trl_hi", got_q[1024], 8'hFC);
      chk("ff_trl_lo", got_q[1025], 8'h00);
      chk("ff_done", done_cnt, 1);

      // start while busy is ignored
      for (int i = 0; i < 1024; i++) mem_a[i] = 8'(i);
      build_exp_a();
      new_frame();
      start_a();
      wait_got("restart", 100, 1000);
      start_a();
      wait_idle("restart", 5000);
      cmp_q("restart");
      chk("restart_done", done_cnt, 1);
      chk("restart_cksum", a_if.checksum, 32'hFE00);
      repeat (5) tick();
      chk("restart_not_queued", a_if.busy, 0);

      // asynchronous reset mid-frame
      new_frame();
      start_a();
      wait_got("midrst", 500, 3000);
      rst = 1'b1;
      #1;
      chk("midrst_busy", a_if.busy, 0);
      chk("midrst_valid", a_if.tx_valid, 0);
      chk("midrst_addr", a_if.addr_b, 0);
      chk("midrst_cksum", a_if.checksum, 0);
      chk("midrst_count", a_if.byte_count, 0);
      chk("midrst_data", a_if.tx_data, 0);
      tick();
      rst = 1'b0;
      tick();
      chk("midrst_no_done", done_cnt, 0);
      new_frame();
      start_a();
      wait_idle("after_rst", 5000);
      cmp_q("after_rst");
      chk("after_rst_done", done_cnt, 1);

      // DEPTH=4 with a 10-cycle stall on byte 2
      exp_q.delete();
      exp_q = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h00, 8'hA0};
      new_frame();
      b_if.start = 1'b1;
      tick();
      b_if.start = 1'b0;
      wait_got("stall", 2, 50);
      b_if.tx_ready = 1'b0;
      n = 0;
      while (!b_if.tx_valid && n < 20) begin
         tick();
         n++;
      end
      for (int i = 0; i < 10; i++) begin
         chk("stall_data", b_if.tx_data, 8'h30);
         chk("stall_addr", b_if.addr_b, 2);
         chk("stall_valid", b_if.tx_valid, 1);
         tick();
      end
      chk("stall_nxfer", got_q.size(), 2);
      b_if.tx_ready = 1'b1;
      wait_idle("stall", 200);
      cmp_q("stall");
      chk("stall_cksum", b_if.checksum, 32'h00A0);
      chk("stall_count", b_if.byte_count, 4);
      chk("stall_done", done_cnt, 1);

      // READ_LAT=3, DEPTH=2
      exp_q.delete();
      exp_q = '{8'hAB, 8'hCD, 8'h01, 8'h78};
      new_frame();
      c_if.start = 1'b1;
      tick();
      c_if.start = 1'b0;
      n = 0;
      while (!c_if.tx_valid && n < 20) begin
         tick();
         n++;
      end
      chk("lat3_latency", n, 4);
      wait_idle("lat3", 200);
      cmp_q("lat3");
      chk("lat3_cksum", c_if.checksum, 32'h0178);
      chk("lat3_count", c_if.byte_count, 2);
      chk("lat3_done", done_cnt, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
